// File: rtl/w_channel_split_pkg.sv
// w_channel_split_pkg: shared FIFO field offsets, FIFO width helper and FSM encoding
package w_channel_split_pkg;
    localparam int TXN_LSB  = 0;
    localparam int XFER_LSB = 3;
    localparam int LEN_LSB  = 6;
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;
    function automatic int ff_width(input int len_w, input int xfer_w, input int txn_w);
        return len_w + xfer_w + txn_w;
    endfunction
endpackage

// File: rtl/w_slice_buf.sv
// w_slice_buf: one wide W beat held and presented as narrow slices selected by idx
module w_slice_buf #(
    parameter int M_W = 128,
    parameter int S_W = 32,
    parameter int XW  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [M_W-1:0]     data_i,
    input  logic [M_W/8-1:0]   strb_i,
    input  logic               last_i,
    input  logic               adv_i,
    input  logic               wrap_i,
    input  logic               flush_i,
    output logic [XW-1:0]      idx_o,
    output logic               valid_o,
    output logic               last_o,
    output logic [S_W-1:0]     data_o,
    output logic [S_W/8-1:0]   strb_o
);
    localparam int RATIO = M_W / S_W;
    localparam int IW    = RATIO > 1 ? $clog2(RATIO) : 1;
    logic [RATIO-1:0][S_W-1:0]   data_q;
    logic [RATIO-1:0][S_W/8-1:0] strb_q;
    logic [XW-1:0]               idx_q;
    logic                        valid_q;
    logic                        last_q;
    // step through slices; a wrap or burst end empties the entry unless a new beat reloads it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            strb_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            if (adv_i) idx_q <= (wrap_i || flush_i) ? '0 : idx_q + 1'b1;
            if (load_i) begin
                data_q  <= data_i;
                strb_q  <= strb_i;
                last_q  <= last_i;
                valid_q <= 1'b1;
            end else if (adv_i && (wrap_i || flush_i)) begin
                valid_q <= 1'b0;
            end
        end
    end
    assign idx_o   = idx_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign data_o  = data_q[idx_q[IW-1:0]];
    assign strb_o  = strb_q[idx_q[IW-1:0]];
endmodule

// File: rtl/w_channel_split.sv
// w_channel_split: AXI W-channel downsizer re-framing wide beats into narrow sub-bursts
module w_channel_split
    import w_channel_split_pkg::*;
#(
    parameter int M_DATA_WIDTH = 128,
    parameter int S_DATA_WIDTH = 32,
    parameter int SUB_TXN_CNT  = 3,
    parameter int SUB_XFER_CNT = 3,
    parameter int SUB_LEN_W    = 8,
    parameter int FF_DATA_OUT  = ff_width(SUB_LEN_W, SUB_XFER_CNT, SUB_TXN_CNT)
) (
    input  logic                      aclk,
    input  logic                      arst_n,
    input  logic [M_DATA_WIDTH-1:0]   m_wdata,
    input  logic [M_DATA_WIDTH/8-1:0] m_wstrb,
    input  logic                      m_wlast,
    input  logic                      m_wvalid,
    output logic                      m_wready,
    output logic [S_DATA_WIDTH-1:0]   s_wdata,
    output logic [S_DATA_WIDTH/8-1:0] s_wstrb,
    output logic                      s_wlast,
    output logic                      s_wvalid,
    input  logic                      s_wready,
    input  logic [FF_DATA_OUT-1:0]    xfer_data_o,
    input  logic                      xfer_empty,
    output logic                      xfer_rd_valid_i,
    output logic                      wlast_err
);
    logic [0:0]              state_q, state_d;
    logic [SUB_LEN_W-1:0]    beats_q, beats_d, beat_cnt_q, beat_cnt_d;
    logic [SUB_XFER_CNT-1:0] xfer_q, xfer_d, idx;
    logic [SUB_TXN_CNT-1:0]  txn_q, txn_d, sub_cnt_q, sub_cnt_d;
    logic                    err_q, err_d;
    logic                    active, buf_valid, buf_last, wrap, load, s_hs, last_hs, final_hs, rel;
    assign active          = state_q == ACTIVE;
    // a beat loaded early for the next burst waits here until that burst's cfg is registered
    assign s_wvalid        = buf_valid && active;
    assign s_wlast         = s_wvalid && beat_cnt_q == beats_q - 1'b1;
    assign s_hs            = s_wvalid && s_wready;
    assign last_hs         = s_hs && s_wlast;
    assign final_hs        = last_hs && sub_cnt_q == txn_q - 1'b1;
    assign wrap            = idx == xfer_q - 1'b1;
    assign rel             = s_hs && wrap;
    assign m_wready        = active && (!buf_valid || (wrap && s_wready));
    assign load            = m_wvalid && m_wready;
    assign xfer_rd_valid_i = arst_n && !active && !xfer_empty;
    assign wlast_err       = err_q;
    w_slice_buf #(
        .M_W(M_DATA_WIDTH),
        .S_W(S_DATA_WIDTH),
        .XW (SUB_XFER_CNT)
    ) u_buf (
        .clk    (aclk),
        .rst_n  (arst_n),
        .load_i (load),
        .data_i (m_wdata),
        .strb_i (m_wstrb),
        .last_i (m_wlast),
        .adv_i  (s_hs),
        .wrap_i (wrap),
        .flush_i(final_hs),
        .idx_o  (idx),
        .valid_o(buf_valid),
        .last_o (buf_last),
        .data_o (s_wdata),
        .strb_o (s_wstrb)
    );
    // cfg capture on pop, burst/sub-burst counting and sticky framing error
    always_comb begin
        state_d = state_q;
        beats_d = beats_q;
        xfer_d  = xfer_q;
        txn_d   = txn_q;
        if (!active && !xfer_empty) begin
            state_d = ACTIVE;
            beats_d = xfer_data_o[LEN_LSB +: SUB_LEN_W];
            xfer_d  = xfer_data_o[XFER_LSB +: SUB_XFER_CNT];
            txn_d   = xfer_data_o[TXN_LSB +: SUB_TXN_CNT];
        end else if (final_hs) begin
            state_d = IDLE;
        end
        beat_cnt_d = last_hs ? '0 : s_hs ? beat_cnt_q + 1'b1 : beat_cnt_q;
        sub_cnt_d  = final_hs ? '0 : last_hs ? sub_cnt_q + 1'b1 : sub_cnt_q;
        err_d      = err_q || (final_hs && !buf_last) || (rel && buf_last && !final_hs);
    end
    // state, cfg and counter registers
    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            state_q    <= IDLE;
            beats_q    <= '0;
            xfer_q     <= '0;
            txn_q      <= '0;
            beat_cnt_q <= '0;
            sub_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beats_q    <= beats_d;
            xfer_q     <= xfer_d;
            txn_q      <= txn_d;
            beat_cnt_q <= beat_cnt_d;
            sub_cnt_q  <= sub_cnt_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_w_channel_split.sv
// tb_w_channel_split: randomized and directed checks of the W-channel downsizer against a beat-queue model
module tb_w_channel_split;
    typedef struct {
        logic [127:0] d;
        logic [15:0]  s;
        logic         l;
        int           x;
    } wb_t;
    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
        logic        l;
        logic        f;
    } nb_t;

    logic         aclk = 1'b0;
    logic         arst_n = 1'b0;
    logic [127:0] m_wdata = '0;
    logic [15:0]  m_wstrb = '0;
    logic         m_wlast = 1'b0;
    logic         m_wvalid = 1'b0;
    logic         m_wready;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic         s_wlast;
    logic         s_wvalid;
    logic         s_wready = 1'b1;
    logic [13:0]  xfer_data_o = '0;
    logic         xfer_empty = 1'b1;
    logic         xfer_rd_valid_i;
    logic         wlast_err;

    w_channel_split dut (
        .aclk(aclk), .arst_n(arst_n),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .xfer_data_o(xfer_data_o), .xfer_empty(xfer_empty), .xfer_rd_valid_i(xfer_rd_valid_i),
        .wlast_err(wlast_err)
    );

    initial forever #5 aclk = ~aclk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int rmode = 0, vmode = 0;
    bit err_mode = 0;
    bit in_burst = 0;
    int buf_rem = 0;
    bit fl_s = 0, fl_m = 0, fl_pop = 0, fl_fin = 0, stall = 0;
    logic [31:0] hd;
    logic [3:0]  hsb;
    logic        hl;
    wb_t mq[$];
    nb_t eq[$];
    logic [13:0]  fifo[$];
    logic [127:0] st_d[$];
    logic [15:0]  st_s[$];
    logic [31:0]  log_d[$];
    logic [3:0]   log_s[$];
    logic         log_l[$];
    int           log_c[$];
    int           pop_cyc[$];
    int           fin_cyc[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // queue one burst: cfg word, its wide beats and every narrow beat the DUT must emit
    task automatic add_burst(input int beats, input int xfer, input int txn, input int last_idx);
        int total, nw;
        wb_t w;
        nb_t e;
        logic [127:0] t;
        logic [15:0]  ts;
        logic [7:0] b8;
        logic [2:0] x3, t3;
        total = beats * txn;
        nw = total / xfer;
        b8 = 8'(beats); x3 = 3'(xfer); t3 = 3'(txn);
        fifo.push_back({b8, x3, t3});
        for (int i = 0; i < nw; i++) begin
            w.d = st_d[i]; w.s = st_s[i]; w.x = xfer;
            w.l = last_idx < 0 ? (i == nw - 1) : (i == last_idx);
            mq.push_back(w);
        end
        for (int n = 0; n < total; n++) begin
            t = st_d[n / xfer];
            ts = st_s[n / xfer];
            e.d = t[(n % xfer) * 32 +: 32];
            e.s = ts[(n % xfer) * 4 +: 4];
            e.l = (n % beats) == beats - 1;
            e.f = n == total - 1;
            eq.push_back(e);
        end
        st_d.delete();
        st_s.delete();
    endtask

    task automatic stage_rand(input int n);
        for (int i = 0; i < n; i++) begin
            st_d.push_back({$urandom, $urandom, $urandom, $urandom});
            st_s.push_back(16'($urandom));
        end
    endtask

    task automatic stage_ramp();
        st_d.push_back({32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000});
        st_d.push_back({32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444});
        st_s.push_back(16'hFFFF);
        st_s.push_back(16'hFFFF);
    endtask

    task automatic clear_logs();
        log_d.delete(); log_s.delete(); log_l.delete(); log_c.delete();
        pop_cyc.delete(); fin_cyc.delete();
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while (!(eq.size() == 0 && fifo.size() == 0 && mq.size() == 0 && !in_burst) && n < budget) begin
            @(negedge aclk);
            n++;
        end
        n_chk++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL %s timeout: %0d narrow beats outstanding, required 0", nm, eq.size());
        end
        repeat (2) @(negedge aclk);
    endtask

    task automatic wait_log(input int cnt, input int budget, input string nm);
        int n = 0;
        while (log_d.size() < cnt && n < budget) begin
            @(negedge aclk);
            n++;
        end
        n_chk++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL %s timeout: %0d narrow beats seen, required %0d", nm, log_d.size(), cnt);
        end
    endtask

    // per-cycle comparison of DUT outputs against the beat-queue model
    initial forever begin
        @(negedge aclk);
        if (!arst_n) begin
            fl_s = 0; fl_m = 0; fl_pop = 0; fl_fin = 0; stall = 0;
        end else begin
            chk("s_wvalid", s_wvalid, in_burst && buf_rem > 0);
            chk("m_wready", m_wready, in_burst && (buf_rem == 0 || (buf_rem == 1 && s_wready)));
            if (stall) begin
                chk("hold_valid", s_wvalid, 1'b1);
                chk("hold_data", s_wdata, hd);
                chk("hold_strb", s_wstrb, hsb);
                chk("hold_last", s_wlast, hl);
            end
            if (fl_fin && fifo.size() > 0) chk("pop_gap", xfer_rd_valid_i, 1'b1);
            fl_fin = 0;
            fl_s = 0;
            if (s_wvalid && s_wready) begin
                if (eq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_beat: got data %0h expected no beat", s_wdata);
                end else begin
                    nb_t e;
                    e = eq.pop_front();
                    chk("s_wdata", s_wdata, e.d);
                    chk("s_wstrb", s_wstrb, e.s);
                    chk("s_wlast", s_wlast, e.l);
                    log_d.push_back(s_wdata); log_s.push_back(s_wstrb);
                    log_l.push_back(s_wlast); log_c.push_back(cyc);
                    fl_s = 1;
                    fl_fin = e.f;
                    if (e.f) fin_cyc.push_back(cyc);
                end
            end
            fl_pop = xfer_rd_valid_i;
            if (xfer_rd_valid_i) begin
                chk("pop_busy", in_burst, 1'b0);
                chk("pop_nonempty", fifo.size() > 0, 1'b1);
                pop_cyc.push_back(cyc);
            end
            fl_m = m_wvalid && m_wready;
            if (!err_mode) chk("wlast_err", wlast_err, 1'b0);
            stall = s_wvalid && !s_wready;
            hd = s_wdata; hsb = s_wstrb; hl = s_wlast;
        end
    end

    // model update from the handshakes of the last edge, then drive new inputs
    initial forever begin
        bit took;
        @(posedge aclk);
        #1;
        cyc++;
        took = fl_m;
        if (fl_s) begin
            buf_rem--;
            if (fl_fin) in_burst = 0;
        end
        if (fl_m && mq.size() > 0) begin
            buf_rem = mq[0].x;
            mq.delete(0);
        end
        if (fl_pop && fifo.size() > 0) begin
            fifo.delete(0);
            in_burst = 1;
        end
        fl_s = 0; fl_m = 0; fl_pop = 0;
        s_wready = rmode == 0 ? 1'b1 : rmode == 1 ? ~s_wready : 1'($urandom_range(1, 0));
        if (!m_wvalid || took) begin
            if (mq.size() > 0 && (vmode == 0 || $urandom_range(3, 0) != 0)) begin
                m_wvalid = 1'b1;
                m_wdata = mq[0].d;
                m_wstrb = mq[0].s;
                m_wlast = mq[0].l;
            end else begin
                m_wvalid = 1'b0;
            end
        end
        xfer_empty = fifo.size() == 0;
        xfer_data_o = fifo.size() > 0 ? fifo[0] : '0;
    end

    initial begin
        int beats, xfer, txn;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_m_wready", m_wready, 1'b0);
        chk("rst_s_wvalid", s_wvalid, 1'b0);
        chk("rst_s_wlast", s_wlast, 1'b0);
        chk("rst_s_wdata", s_wdata, 32'h0);
        chk("rst_s_wstrb", s_wstrb, 4'h0);
        chk("rst_pop", xfer_rd_valid_i, 1'b0);
        chk("rst_err", wlast_err, 1'b0);
        @(posedge aclk); #2; arst_n = 1'b1;

        clear_logs(); rmode = 0; vmode = 0;
        stage_ramp(); add_burst(8, 4, 1, -1);
        wait_idle(200, "t1");
        chk("t1_first", log_d[0], 32'h00000000);
        chk("t1_third", log_d[2], 32'h22222222);
        chk("t1_last_data", log_d[7], 32'h77777777);
        chk("t1_consecutive", log_c[7] - log_c[0], 7);
        chk("t1_wlast_pos", {log_l[7], log_l[6], log_l[5], log_l[4], log_l[3], log_l[2], log_l[1], log_l[0]}, 8'h80);
        chk("t1_pops", pop_cyc.size(), 1);
        chk("t1_err", wlast_err, 1'b0);

        clear_logs(); rmode = 1;
        stage_ramp(); add_burst(8, 4, 1, -1);
        wait_idle(300, "t2");
        chk("t2_slice4", log_d[4], 32'h44444444);
        chk("t2_count", log_d.size(), 8);

        clear_logs(); rmode = 0;
        stage_rand(1); add_burst(2, 4, 2, -1);
        wait_idle(200, "t3");
        chk("t3_wlast_pos", {log_l[3], log_l[2], log_l[1], log_l[0]}, 4'b1010);
        chk("t3_idle_ready", m_wready, 1'b0);

        clear_logs();
        st_d.push_back({$urandom, $urandom, $urandom, $urandom}); st_s.push_back(16'h00F0);
        add_burst(4, 4, 1, -1);
        wait_idle(200, "t4");
        chk("t4_strobes", {log_s[3], log_s[2], log_s[1], log_s[0]}, 16'h00F0);
        chk("t4_count", log_s.size(), 4);

        clear_logs();
        stage_rand(2); add_burst(8, 4, 1, -1);
        stage_rand(1); add_burst(2, 4, 2, -1);
        wait_idle(300, "t5");
        chk("t5_pops", pop_cyc.size(), 2);
        chk("t5_gap", pop_cyc[1] - fin_cyc[0], 1);

        clear_logs(); err_mode = 1;
        stage_ramp(); add_burst(8, 4, 1, 0);
        wait_log(5, 200, "t6_beats");
        chk("t6_err_set", wlast_err, 1'b1);
        wait_idle(200, "t6");
        repeat (3) @(negedge aclk);
        chk("t6_err_sticky", wlast_err, 1'b1);

        clear_logs();
        stage_ramp(); add_burst(8, 4, 1, -1);
        wait_log(3, 200, "t7_beats");
        @(posedge aclk); #2; arst_n = 1'b0;
        @(posedge aclk); #2; arst_n = 1'b1;
        eq.delete(); mq.delete(); fifo.delete();
        in_burst = 0; buf_rem = 0; err_mode = 0;
        m_wvalid = 1'b0; xfer_empty = 1'b1; xfer_data_o = '0;
        @(negedge aclk);
        chk("t7_m_wready", m_wready, 1'b0);
        chk("t7_s_wvalid", s_wvalid, 1'b0);
        chk("t7_s_wlast", s_wlast, 1'b0);
        chk("t7_s_wdata", s_wdata, 32'h0);
        chk("t7_s_wstrb", s_wstrb, 4'h0);
        chk("t7_pop", xfer_rd_valid_i, 1'b0);
        chk("t7_err", wlast_err, 1'b0);

        rmode = 2; vmode = 1;
        for (int b = 0; b < 40; b++) begin
            do begin
                beats = $urandom_range(8, 1);
                xfer = $urandom_range(4, 1);
                txn = $urandom_range(4, 1);
            end while ((beats * txn) % xfer != 0);
            stage_rand(beats * txn / xfer);
            add_burst(beats, xfer, txn, -1);
        end
        wait_idle(30000, "random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
